mod_gather_arb: RTL and testbench

Arbitration and sequencing controller that owns the 4-to-16 byte gather buffer ahead of the AES256 core and shares it between two requesters: the key source and the data source. Each source offers 32-bit words (4 bytes) over valid/ready. A data transaction is one 128-bit block; a key transaction is two consecutive 128-bit blocks (low half, then high half). Assembled blocks go downstream over valid/ready with a tag naming their kind.

---
 rtl/aes_gather_pkg.sv | 21 ++
 rtl/mod_gather_arb_gather_buf.sv | 38 +++
 rtl/mod_gather_arb.sv | 141 ++++++++++++++
 tb/tb_mod_gather_arb.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_gather_pkg.sv
// Shared types and constants for the AES256 gather-buffer arbiter.
package aes_gather_pkg;

    localparam int NIN        = 4;                // bytes per input word
    localparam int NOUT       = 16;               // bytes per output block
    localparam int KEY_BLOCKS = 2;                // blocks per key transaction
    localparam int NWORDS     = NOUT / NIN;       // words per block
    localparam int WIDX_W     = $clog2(NWORDS);
    localparam int BCNT_W     = (KEY_BLOCKS > 1) ? $clog2(KEY_BLOCKS) : 1;

    typedef logic [NIN-1:0][7:0]  word_t;
    typedef logic [NOUT-1:0][7:0] block_t;

    typedef enum logic [1:0] {IDLE, GATHER, HOLD} state_t;
    typedef enum logic {GR_KEY, GR_DATA} grant_t;

    localparam logic [1:0] TAG_DATA   = 2'b00;
    localparam logic [1:0] TAG_KEY_LO = 2'b01;
    localparam logic [1:0] TAG_KEY_HI = 2'b10;

endpackage

// File: rtl/mod_gather_arb_gather_buf.sv
// Word-indexed byte buffer: each write lands one input word at byte offset NIN*widx.
module gather_buf
    import aes_gather_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [WIDX_W-1:0] widx,
    input  word_t             wdata,
    output block_t            buf_q,
    output block_t            buf_next
);

    // Merge the incoming word into the current buffer contents.
    always_comb begin
        // NOTE: default assignment first so every path drives buf_next and no latch is inferred.
        buf_next = buf_q;
        for (int w = 0; w < NWORDS; w++) begin
            for (int b = 0; b < NIN; b++) begin
                if (wr_en && widx == WIDX_W'(w)) begin
                    buf_next[NIN*w+b] = wdata[b];
                end
            end
        end
    end

    // Buffer storage; cleared so an aborted partial block never leaks into a later one.
    always_ff @(posedge clk) begin
        // NOTE: the buffer is tiny, so it is reset explicitly rather than left undefined.
        if (reset || clr) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_next;
        end
    end

endmodule

// File: rtl/mod_gather_arb.sv
// Two-requester arbiter and sequencer feeding 128-bit blocks to the AES256 core.
module mod_gather_arb
    import aes_gather_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       key_valid,
    output logic       key_ready,
    input  word_t      key_i,
    input  logic       dat_valid,
    output logic       dat_ready,
    input  word_t      dat_i,
    output block_t     o,
    output logic       o_valid,
    input  logic       o_ready,
    output logic [1:0] o_tag,
    output logic       busy
);

    state_t              state_q, state_d;
    grant_t              grant_q, grant_d;
    grant_t              last_grant_q, last_grant_d;
    logic [WIDX_W-1:0]   wcnt_q, wcnt_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [1:0]          tag_q, tag_d;
    block_t              o_q;
    block_t              buf_q, buf_next;
    word_t               word_in;
    logic                hs;
    logic                load_o;

    assign key_ready = (state_q == GATHER) && (grant_q == GR_KEY);
    assign dat_ready = (state_q == GATHER) && (grant_q == GR_DATA);
    assign hs        = (grant_q == GR_KEY) ? (key_valid && key_ready) : (dat_valid && dat_ready);
    assign word_in   = (grant_q == GR_KEY) ? key_i : dat_i;
    assign o         = o_q;
    assign o_tag     = tag_q;
    assign o_valid   = (state_q == HOLD);
    assign busy      = (state_q != IDLE);

    // Handshakes that coincide with flush are dropped along with the partial block.
    gather_buf u_buf (
        .clk      (clk),
        .reset    (reset),
        .clr      (flush),
        .wr_en    (hs && !flush),
        .widx     (wcnt_q),
        .wdata    (word_in),
        .buf_q    (buf_q),
        .buf_next (buf_next)
    );

    // Next-state, round-robin grant and counter logic.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wcnt_d       = wcnt_q;
        bcnt_d       = bcnt_q;
        tag_d        = tag_q;
        load_o       = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_valid || dat_valid) begin
                    if (key_valid && dat_valid) begin
                        grant_d = (last_grant_q == GR_DATA) ? GR_KEY : GR_DATA;
                    end else begin
                        grant_d = key_valid ? GR_KEY : GR_DATA;
                    end
                    last_grant_d = grant_d;
                    state_d      = GATHER;
                end
            end
            GATHER: begin
                if (hs) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == WIDX_W'(NWORDS-1)) begin
                        load_o  = 1'b1;
                        state_d = HOLD;
                        if (grant_q == GR_DATA) begin
                            tag_d = TAG_DATA;
                        end else begin
                            tag_d = (bcnt_q == '0) ? TAG_KEY_LO : TAG_KEY_HI;
                        end
                    end
                end
            end
            HOLD: begin
                if (o_ready) begin
                    if (grant_q == GR_KEY && bcnt_q < BCNT_W'(KEY_BLOCKS-1)) begin
                        bcnt_d  = bcnt_q + 1'b1;
                        tag_d   = TAG_KEY_HI;
                        state_d = GATHER;
                    end else begin
                        bcnt_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register; flush aborts to IDLE, reset takes priority.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q <= IDLE;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant, counters, tag and output block registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q      <= GR_DATA;
            last_grant_q <= GR_DATA;
            wcnt_q       <= '0;
            bcnt_q       <= '0;
            tag_q        <= TAG_DATA;
            o_q          <= '0;
        end else if (flush) begin
            wcnt_q       <= '0;
            bcnt_q       <= '0;
        end else begin
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wcnt_q       <= wcnt_d;
            bcnt_q       <= bcnt_d;
            tag_q        <= tag_d;
            if (load_o) begin
                o_q <= buf_next;
            end
        end
    end

endmodule

// File: tb/tb_mod_gather_arb.sv
// Directed self-checking bench for mod_gather_arb.
module tb_mod_gather_arb;
    import aes_gather_pkg::*;

    logic       clk = 1'b0;
    logic       reset, flush;
    logic       key_valid, key_ready, dat_valid, dat_ready;
    word_t      key_i, dat_i;
    block_t     o;
    logic       o_valid, o_ready, busy;
    logic [1:0] o_tag;

    int errors = 0;
    int checks = 0;
    int excl_viol = 0;
    bit mon_excl = 1'b0;

    always #5 clk = ~clk;

    mod_gather_arb dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_i     (key_i),
        .dat_valid (dat_valid),
        .dat_ready (dat_ready),
        .dat_i     (dat_i),
        .o         (o),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_tag     (o_tag),
        .busy      (busy)
    );

    // Counts any cycle where the data source is offered ready during a key transaction.
    always @(negedge clk) begin
        if (mon_excl && dat_ready === 1'b1) excl_viol++;
    end

    function automatic block_t mk_block(input logic [7:0] base);
        block_t b;
        for (int i = 0; i < NOUT; i++) b[i] = base + 8'(i);
        return b;
    endfunction

    function automatic word_t mk_word(input logic [7:0] base, input int w);
        word_t x;
        for (int i = 0; i < NIN; i++) x[i] = base + 8'(NIN*w + i);
        return x;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    // Offer one word and return at the negedge after its handshake edge.
    task automatic send(input bit is_key, input word_t w);
        int n;
        n = 0;
        if (is_key) begin key_valid = 1'b1; key_i = w; end
        else        begin dat_valid = 1'b1; dat_i = w; end
        while ((is_key ? key_ready : dat_ready) !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL send_timeout: ready still low after %0d cycles, required 1", n);
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; key_valid = 1'b0; dat_valid = 1'b0;
        o_ready = 1'b0; key_i = '0; dat_i = '0;
        step(); step();
        reset = 1'b0;
        checks++; if (o !== '0)         begin errors++; $display("FAIL reset_o: got %h, expected 0", o); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %b, expected 0", o_valid); end
        checks++; if (o_tag !== 2'b00)  begin errors++; $display("FAIL reset_o_tag: got %b, expected 00", o_tag); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (key_ready !== 1'b0 || dat_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got key=%b dat=%b, expected 0 0", key_ready, dat_ready);
        end
    endtask

    task automatic test_data_only();
        for (int w = 0; w < 4; w++) begin
            send(1'b0, mk_word(8'h00, w));
            if (w < 3) begin
                checks++;
                if (key_ready !== 1'b0) begin errors++; $display("FAIL data_key_ready: got %b, expected 0", key_ready); end
            end
        end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL data_o_valid: got %b, expected 1", o_valid); end
        checks++; if (o !== mk_block(8'h00)) begin errors++; $display("FAIL data_o: got %h, expected %h", o, mk_block(8'h00)); end
        checks++; if (o_tag !== TAG_DATA) begin errors++; $display("FAIL data_tag: got %b, expected 00", o_tag); end
        dat_valid = 1'b0;
        o_ready = 1'b1;
        step();
        o_ready = 1'b0;
        checks++; if (o_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL data_done: got o_valid=%b busy=%b, expected 0 0", o_valid, busy);
        end
    endtask

    task automatic test_key_only();
        excl_viol = 0;
        mon_excl = 1'b1;
        dat_valid = 1'b1;
        dat_i = mk_word(8'hE0, 0);
        o_ready = 1'b1;
        for (int w = 0; w < 4; w++) send(1'b1, mk_word(8'h10, w));
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL key_lo_valid: got %b, expected 1", o_valid); end
        checks++; if (o !== mk_block(8'h10)) begin errors++; $display("FAIL key_lo_o: got %h, expected %h", o, mk_block(8'h10)); end
        checks++; if (o_tag !== TAG_KEY_LO) begin errors++; $display("FAIL key_lo_tag: got %b, expected 01", o_tag); end
        for (int w = 4; w < 8; w++) send(1'b1, mk_word(8'h10, w));
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL key_hi_valid: got %b, expected 1", o_valid); end
        checks++; if (o !== mk_block(8'h20)) begin errors++; $display("FAIL key_hi_o: got %h, expected %h", o, mk_block(8'h20)); end
        checks++; if (o_tag !== TAG_KEY_HI) begin errors++; $display("FAIL key_hi_tag: got %b, expected 10", o_tag); end
        step();
        mon_excl = 1'b0;
        checks++; if (excl_viol != 0) begin errors++; $display("FAIL key_excl: dat_ready high %0d cycles, expected 0", excl_viol); end
        // Both sources still valid: the data source must win this round.
        step();
        checks++; if (dat_ready !== 1'b1 || key_ready !== 1'b0) begin
            errors++; $display("FAIL round_robin: got key=%b dat=%b, expected 0 1", key_ready, dat_ready);
        end
        key_valid = 1'b0; dat_valid = 1'b0; o_ready = 1'b0;
        pulse_flush();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_flush_busy: got %b, expected 0", busy); end
    endtask

    task automatic test_both_from_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        key_valid = 1'b1; dat_valid = 1'b1;
        step();
        checks++; if (key_ready !== 1'b1 || dat_ready !== 1'b0) begin
            errors++; $display("FAIL first_tie: got key=%b dat=%b, expected 1 0", key_ready, dat_ready);
        end
        key_valid = 1'b0; dat_valid = 1'b0;
        pulse_flush();
    endtask

    task automatic test_backpressure();
        for (int w = 0; w < 4; w++) send(1'b0, mk_word(8'hA0, w));
        key_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b, expected 1", c, o_valid); end
            checks++; if (o !== mk_block(8'hA0)) begin errors++; $display("FAIL bp_o[%0d]: got %h, expected %h", c, o, mk_block(8'hA0)); end
            checks++; if (o_tag !== TAG_DATA) begin errors++; $display("FAIL bp_tag[%0d]: got %b, expected 00", c, o_tag); end
            checks++; if (key_ready !== 1'b0 || dat_ready !== 1'b0) begin
                errors++; $display("FAIL bp_ready[%0d]: got key=%b dat=%b, expected 0 0", c, key_ready, dat_ready);
            end
            step();
        end
        o_ready = 1'b1;
        step();
        key_valid = 1'b0; dat_valid = 1'b0; o_ready = 1'b0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b, expected 0", o_valid); end
    endtask

    task automatic test_flush();
        send(1'b0, mk_word(8'h30, 0));
        send(1'b0, mk_word(8'h30, 1));
        dat_i = mk_word(8'h30, 2);
        flush = 1'b1;
        step();
        flush = 1'b0; dat_valid = 1'b0;
        checks++; if (o_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL flush_state: got o_valid=%b busy=%b, expected 0 0", o_valid, busy);
        end
        checks++; if (o !== mk_block(8'hA0)) begin errors++; $display("FAIL flush_o_kept: got %h, expected %h", o, mk_block(8'hA0)); end
        for (int w = 0; w < 4; w++) send(1'b0, mk_word(8'h40, w));
        checks++; if (o !== mk_block(8'h40) || o_valid !== 1'b1) begin
            errors++; $display("FAIL flush_reload: got %h valid=%b, expected %h valid=1", o, o_valid, mk_block(8'h40));
        end
        dat_valid = 1'b0; o_ready = 1'b1;
        step();
        o_ready = 1'b0;
    endtask

    task automatic test_reset_in_hold();
        for (int w = 0; w < 4; w++) send(1'b1, mk_word(8'h50, w));
        key_valid = 1'b0;
        checks++; if (o_valid !== 1'b1 || o_tag !== TAG_KEY_LO) begin
            errors++; $display("FAIL rst_hold_pre: got valid=%b tag=%b, expected 1 01", o_valid, o_tag);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (o !== '0 || o_valid !== 1'b0 || o_tag !== 2'b00 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_hold_post: got o=%h valid=%b tag=%b busy=%b, expected 0 0 00 0", o, o_valid, o_tag, busy);
        end
        checks++; if (key_ready !== 1'b0 || dat_ready !== 1'b0) begin
            errors++; $display("FAIL rst_hold_ready: got key=%b dat=%b, expected 0 0", key_ready, dat_ready);
        end
        for (int w = 0; w < 4; w++) send(1'b1, mk_word(8'h60, w));
        key_valid = 1'b0;
        checks++; if (o_tag !== TAG_KEY_LO || o !== mk_block(8'h60)) begin
            errors++; $display("FAIL rst_restart: got tag=%b o=%h, expected 01 %h", o_tag, o, mk_block(8'h60));
        end
        pulse_flush();
    endtask

    initial begin
        test_reset();
        test_data_only();
        test_key_only();
        test_both_from_reset();
        test_backpressure();
        test_flush();
        test_reset_in_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
